muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; operand and result widths are fixed at 32 bits.
REQ-002 clk_i  input  1  single clock; all state updates on posedge.
REQ-003 rstn_i  input  1  reset, asynchronous and active-low.
REQ-004 start_i  input  1  request a new operation; sampled only in IDLE.
REQ-005 op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_i  input  32  operand A, taken from the register-file rs1 read port.
REQ-007 rs2_i  input  32  operand B, taken from the register-file rs2 read port.
REQ-008 rd_addr_i  input  5  destination register index for the operation.
REQ-009 busy_o  output  1  high while an operation is in progress (CALC or DONE).
REQ-010 done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
REQ-011 result_o  output  32  operation result; drives the register-file write data.
REQ-012 rd_addr_o  output  5  captured rd_addr_i; drives the register-file write address.
REQ-013 write_en_o  output  1  equals done_o; drives the register-file write enable.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-015 IDLE with start_i=1: latch op_i, rs1_i, rs2_i and rd_addr_i; go to CALC. The next cycle is CALC cycle 1.
REQ-016 IDLE with start_i=0: stay in IDLE.
REQ-017 CALC SHALL run exactly 32 iterations, one per cycle, using a 6-bit counter. After the 32nd iteration, go to DONE.
REQ-018 Multiply SHALL use a radix-2 shift-add over the magnitudes into a 64-bit product, then apply the sign correction.
REQ-019 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-020 Signedness: MULH treats both operands as signed, MULHSU treats rs1 as signed and rs2 as unsigned, MULHU treats both as unsigned.
REQ-021 Divide SHALL use radix-2 restoring division on magnitudes. Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
REQ-022 Divide by zero: skip CALC and go IDLE -> DONE. Quotient = 0xFFFFFFFF; remainder = rs1.
REQ-023 Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): skip CALC and go IDLE -> DONE. Quotient = 0x80000000; remainder = 0.
REQ-024 DONE SHALL assert done_o and write_en_o for exactly one cycle, then return to IDLE.
REQ-025 Latency: done_o is high 33 cycles after the start cycle in the normal case, and 1 cycle after it in the fast paths.
REQ-026 start_i asserted while busy_o=1 SHALL be ignored, with no queuing.
REQ-027 start_i asserted in the same cycle DONE returns to IDLE SHALL be ignored; a new start is accepted from the following IDLE cycle onward.
REQ-028 result_o and rd_addr_o SHALL hold their values from the last DONE until the next DONE.
REQ-029 busy_o SHALL be low in IDLE.

Reset
REQ-030 rstn_i=0 SHALL immediately force the following, regardless of clk_i and of any operation in progress:
- state to IDLE
- busy_o, done_o and write_en_o to 0
- result_o to 0x00000000 and rd_addr_o to 0
- iteration counter and datapath registers to 0
REQ-031 An operation interrupted by reset SHALL never produce done_o, and SHALL not resume.
REQ-032 The first start_i SHALL be accepted on the first posedge after rstn_i deasserts.

Configuration
REQ-033 Macro MULDIV_FAST_MUL_EN SHALL control how multiplies are computed.
REQ-034 With MULDIV_FAST_MUL_EN defined, multiplies SHALL be computed by a single-cycle 33x33 signed multiplier and go IDLE -> DONE, with done_o 1 cycle after start. Divide behaviour is unchanged.
REQ-035 Without MULDIV_FAST_MUL_EN, multiplies SHALL use the 32-cycle iterative path described in REQ-018.

Verification
REQ-036 MUL rs1=7, rs2=0xFFFFFFFD -> result_o=0xFFFFFFEB with done_o 33 cycles after start (1 cycle with MULDIV_FAST_MUL_EN), rd_addr_o equal to the issued rd, busy_o high throughout.
REQ-037 MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULH on the same operands -> 0x00000000; MULHSU 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF.
REQ-038 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-039 DIVU 0x1234 / 0 -> 0xFFFFFFFF, and REMU 0x1234 / 0 -> 0x1234, with done_o 1 cycle after start. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM of the same operands -> 0.
REQ-040 Start a DIV, pulse start_i again at CALC cycle 10 with different operands, then assert rstn_i=0 at CALC cycle 20. Required:
- the second start has no effect
- outputs clear immediately on reset
- no done_o appears
- a MUL 3 * 4 issued after reset yields 12

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider.
// Define MULDIV_FAST_MUL_EN to compute multiplies in one cycle with a 33x33 signed multiplier.
module muldiv_unit (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o,
  output logic        write_en_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 6;
  localparam int unsigned PW   = 2 * XLEN;
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   opb_q;
  logic              neg_q;
  logic              rneg_q;
  logic [4:0]        rd_q;

  logic              is_div;
  logic              a_signed;
  logic              b_signed;
  logic              sa;
  logic              sb;
  logic              div_zero;
  logic              div_ovf;
  logic              fast_path;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   fast_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]   fa;
  logic signed [XLEN:0]   fb;
  logic signed [PW-1:0]   fp;

  // Sign bit extends only the operands the opcode treats as signed
  assign fa = {sa, rs1_i};
  assign fb = {sb, rs2_i};
  assign fp = PW'(fa) * PW'(fb);
`endif

  // Operand decode and single-cycle results
  always_comb begin
    is_div    = op_i[2];
    a_signed  = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_signed  = is_div ? ~op_i[0] : ~op_i[1];
    sa        = a_signed & rs1_i[XLEN-1];
    sb        = b_signed & rs2_i[XLEN-1];
    a_mag     = sa ? -rs1_i : rs1_i;
    b_mag     = sb ? -rs2_i : rs2_i;
    div_zero  = is_div && (rs2_i == '0);
    div_ovf   = is_div && !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    fast_path = div_zero | div_ovf;
    fast_res  = '0;
    if (div_zero) begin
      fast_res = op_i[1] ? rs1_i : '1;
    end else if (div_ovf) begin
      fast_res = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div) begin
      fast_res = (op_i[1:0] == 2'b00) ? fp[XLEN-1:0] : fp[PW-1:XLEN];
    end
    fast_path = fast_path | ~is_div;
`endif
  end

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [PW-1:0]     prod;
  logic [XLEN-1:0]   calc_res;

  // One iteration: hi/lo hold product (mul) or remainder/quotient (div)
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    ge      = shifted >= {1'b0, opb_q};
    if (op_q[2]) begin
      hi_n = ge ? XLEN'(shifted - {1'b0, opb_q}) : shifted[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
    prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    if (op_q[2]) begin
      calc_res = op_q[1] ? (rneg_q ? -hi_n : hi_n) : (neg_q ? -lo_n : lo_n);
    end else begin
      calc_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    end
  end

  // Control FSM with datapath and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      rd_q       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      write_en_o <= 1'b0;
      result_o   <= '0;
      rd_addr_o  <= '0;
    end else begin
      done_o     <= 1'b0;
      write_en_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            op_q   <= op_i;
            rd_q   <= rd_addr_i;
            busy_o <= 1'b1;
            if (fast_path) begin
              state      <= S_DONE;
              result_o   <= fast_res;
              rd_addr_o  <= rd_addr_i;
              done_o     <= 1'b1;
              write_en_o <= 1'b1;
            end else begin
              state  <= S_CALC;
              cnt    <= '0;
              hi_q   <= '0;
              lo_q   <= is_div ? a_mag : b_mag;
              opb_q  <= is_div ? b_mag : a_mag;
              neg_q  <= sa ^ sb;
              rneg_q <= sa;
            end
          end
        end
        S_CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state      <= S_DONE;
            result_o   <= calc_res;
            rd_addr_o  <= rd_q;
            done_o     <= 1'b1;
            write_en_o <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: RV32M ops, fast paths, start
// filtering, result hold and mid-operation reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int FAST_LAT = 1;

  muldiv_unit dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .start_i    (start),
    .op_i       (op),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .rd_addr_i  (rd),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .rd_addr_o  (rd_out),
    .write_en_o (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one op and checks latency, outputs and the return to idle
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    logic busy_dropped;
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    rd    = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs1   = 32'h5A5A_5A5A;
    rs2   = 32'hA5A5_A5A5;
    rd    = ~r;
    lat = 0;
    busy_dropped = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (!busy) busy_dropped = 1'b1;
      if (done) break;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " rd_addr"}, 32'(rd_out), 32'(r));
    check({tag, " write_en"}, 32'(we), 32'(1));
    check({tag, " busy held"}, 32'(busy_dropped), 32'(0));
    @(negedge clk);
    check({tag, " done pulse"}, 32'({done, we}), 32'(0));
    check({tag, " idle busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    logic anomaly;
    rstn  = 1'b0;
    start = 1'b0;
    op    = '0;
    rs1   = '0;
    rs2   = '0;
    rd    = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'({done, we}), 32'(0));
    check("reset result", result, 32'h0);
    check("reset rd_addr", 32'(rd_out), 32'(0));
    rstn = 1'b1;

    run_op("mul",    OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, MUL_LAT);
    run_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, MUL_LAT);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, MUL_LAT);
    run_op("mulh2",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000, MUL_LAT);
    run_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFF, DIV_LAT);
    run_op("divu",   OP_DIVU,   32'd100,      32'd7,        5'd12, 32'd14,        DIV_LAT);
    run_op("remu",   OP_REMU,   32'd100,      32'd7,        5'd13, 32'd2,         DIV_LAT);
    run_op("divneg", OP_DIV,    32'd100,      32'hFFFF_FFF9, 5'd14, 32'hFFFF_FFF2, DIV_LAT);
    run_op("divu0",  OP_DIVU,   32'h1234,     32'd0,        5'd15, 32'hFFFF_FFFF, FAST_LAT);
    run_op("remu0",  OP_REMU,   32'h1234,     32'd0,        5'd16, 32'h0000_1234, FAST_LAT);
    run_op("rem0",   OP_REM,    32'hFFFF_FFFB, 32'd0,        5'd17, 32'hFFFF_FFFB, FAST_LAT);
    run_op("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, FAST_LAT);
    run_op("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, FAST_LAT);

    // Result and rd hold until the next completion
    repeat (4) @(negedge clk);
    check("hold result", result, 32'h0000_0000);
    check("hold rd_addr", 32'(rd_out), 32'(19));

    // start held through the DONE cycle must not launch a second op
    start = 1'b1;
    op    = OP_DIVU;
    rs1   = 32'd5;
    rs2   = 32'd0;
    rd    = 5'd1;
    @(negedge clk);
    check("dstart done", 32'(done), 32'(1));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("dstart ignored", 32'({busy, done}), 32'(0));

    // Reset in the middle of a DIV after an ignored second start
    start = 1'b1;
    op    = OP_DIV;
    rs1   = 32'd1000;
    rs2   = 32'd3;
    rd    = 5'd21;
    @(posedge clk);
    #1;
    start = 1'b0;
    anomaly = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 10) begin
        start = 1'b1;
        op    = OP_MUL;
        rs1   = 32'd9;
        rs2   = 32'd9;
        rd    = 5'd22;
      end else begin
        start = 1'b0;
      end
      if (!busy || done) anomaly = 1'b1;
    end
    check("busy during calc", 32'(anomaly), 32'(0));
    rstn = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'({done, we}), 32'(0));
    check("rst result", result, 32'h0);
    check("rst rd_addr", 32'(rd_out), 32'(0));
    anomaly = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) anomaly = 1'b1;
    end
    check("rst held quiet", 32'(anomaly), 32'(0));
    rstn = 1'b1;
    run_op("mul after rst", OP_MUL, 32'd3, 32'd4, 5'd3, 32'd12, MUL_LAT);
    anomaly = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) anomaly = 1'b1;
    end
    check("no stale done", 32'(anomaly), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
